operand_fetch_stage: RTL and testbench

- ID/EX stage of the 16-bit pipelined CPU. It sits directly upstream of the execute stage and drives the three read-index ports of the register file.
- Takes decoded register indices from the decoder and reads S/T/M operands plus the T flag.
- Applies EX/MEM forwarding, detects load-use hazards, inserts bubbles, and latches the ID/EX pipeline register under stall and flush control.

---
 rtl/operand_fetch_stage_pkg.sv | 47 ++++
 rtl/operand_fetch_stage_if.sv | 29 ++
 rtl/operand_fetch_stage_forward_mux.sv | 38 +++
 rtl/operand_fetch_stage.sv | 145 ++++++++++++++
 tb/tb_operand_fetch_stage.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_fetch_stage_pkg.sv
// Shared CPU definitions: register index map, data widths and the ID/EX register layout.
package cpu_defs;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned CTRL_W      = 16;
    localparam int unsigned STALL_CNT_W = 16;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam idx_t REG_IH     = 4'd8;
    localparam idx_t REG_SP     = 4'd9;
    localparam idx_t REG_RA     = 4'd10;
    localparam idx_t REG_ILL_LO = 4'd11;
    localparam idx_t REG_ILL_HI = 4'd14;
    localparam idx_t REG_NONE   = 4'hF;

    typedef struct packed {
        logic              valid;
        idx_t              dst;
        logic              writes_t;
        logic              is_load;
        logic              t;
        data_t             op_s;
        data_t             op_t;
        data_t             op_m;
        logic [CTRL_W-1:0] ctrl;
        data_t             imm;
    } idex_t;

    // Illegal indices behave exactly like an unused source.
    function automatic idx_t sanitize_idx(idx_t idx);
        if (idx >= REG_ILL_LO && idx <= REG_ILL_HI) begin
            return REG_NONE;
        end
        return idx;
    endfunction

    function automatic idex_t idex_reset();
        idex_t r;
        r     = '0;
        r.dst = REG_NONE;
        return r;
    endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Decoder -> operand fetch handshake: decoded fields forward, stall back.
interface operand_fetch_stage_if;
    import cpu_defs::*;

    logic              in_valid;
    idx_t              in_idxS;
    idx_t              in_idxT;
    idx_t              in_idxM;
    idx_t              in_dst;
    logic              in_useT;
    logic              in_writesT;
    logic              in_isLoad;
    logic [CTRL_W-1:0] in_ctrl;
    data_t             in_imm;
    logic              stall_out;

    modport master (
        output in_valid, in_idxS, in_idxT, in_idxM, in_dst, in_useT, in_writesT, in_isLoad,
        output in_ctrl, in_imm,
        input  stall_out
    );

    modport slave (
        input  in_valid, in_idxS, in_idxT, in_idxM, in_dst, in_useT, in_writesT, in_isLoad,
        input  in_ctrl, in_imm,
        output stall_out
    );

endinterface

// File: rtl/operand_fetch_stage_forward_mux.sv
// One operand source: EX/MEM forwarding over the register-file value, plus EX load-hit flag.
module operand_forward_mux
    import cpu_defs::*;
(
    input  idx_t  src_i,
    input  data_t rf_i,
    input  logic  ex_valid_i,
    input  logic  ex_is_load_i,
    input  idx_t  ex_dst_i,
    input  data_t ex_result_i,
    input  logic  mem_valid_i,
    input  idx_t  mem_dst_i,
    input  data_t mem_result_i,
    output data_t op_o,
    output logic  load_hit_o
);

    logic used;
    logic ex_hit;
    logic mem_hit;

    always_comb begin
        used       = (src_i != REG_NONE);
        ex_hit     = used && ex_valid_i && (src_i == ex_dst_i);
        mem_hit    = used && mem_valid_i && (src_i == mem_dst_i);
        load_hit_o = ex_hit && ex_is_load_i;
        if (!used) begin
            op_o = '0;
        end else if (ex_hit && !ex_is_load_i) begin
            op_o = ex_result_i;
        end else if (mem_hit) begin
            op_o = mem_result_i;
        end else begin
            op_o = rf_i;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// ID/EX stage: register-file reads, EX/MEM forwarding, load-use bubbles and the ID/EX register.
module operand_fetch_stage
    import cpu_defs::*;
(
    input  logic                   clk,
    input  logic                   rst,
    operand_fetch_stage_if.slave   dec_io,
    output idx_t                   readIndexS,
    output idx_t                   readIndexT,
    output idx_t                   readIndexM,
    input  data_t                  readResultS,
    input  data_t                  readResultT,
    input  data_t                  readResultM,
    input  logic                   tResult,
    input  logic                   ex_valid,
    input  logic                   ex_isLoad,
    input  logic                   ex_writesT,
    input  logic                   ex_t,
    input  idx_t                   ex_dst,
    input  data_t                  ex_result,
    input  logic                   mem_valid,
    input  logic                   mem_writesT,
    input  logic                   mem_t,
    input  idx_t                   mem_dst,
    input  data_t                  mem_result,
    input  logic                   stall_in,
    input  logic                   flush,
    output logic                   out_valid,
    output data_t                  out_opS,
    output data_t                  out_opT,
    output data_t                  out_opM,
    output logic                   out_t,
    output idx_t                   out_dst,
    output logic                   out_writesT,
    output logic                   out_isLoad,
    output logic [CTRL_W-1:0]      out_ctrl,
    output data_t                  out_imm,
    output logic [STALL_CNT_W-1:0] stall_count
);

    idx_t  idx_s, idx_t_src, idx_m;
    data_t op_s, op_t, op_m;
    logic  hit_s, hit_t, hit_m;
    logic  t_fwd;
    logic  hazard;

    idex_t                  idex_d, idex_q;
    logic [STALL_CNT_W-1:0] stall_count_d, stall_count_q;

    always_comb begin
        idx_s     = sanitize_idx(dec_io.in_idxS);
        idx_t_src = sanitize_idx(dec_io.in_idxT);
        idx_m     = sanitize_idx(dec_io.in_idxM);
    end

    assign readIndexS = idx_s;
    assign readIndexT = idx_t_src;
    assign readIndexM = idx_m;

    operand_forward_mux u_mux_s (
        .src_i(idx_s), .rf_i(readResultS),
        .ex_valid_i(ex_valid), .ex_is_load_i(ex_isLoad), .ex_dst_i(ex_dst),
        .ex_result_i(ex_result), .mem_valid_i(mem_valid), .mem_dst_i(mem_dst),
        .mem_result_i(mem_result), .op_o(op_s), .load_hit_o(hit_s)
    );

    operand_forward_mux u_mux_t (
        .src_i(idx_t_src), .rf_i(readResultT),
        .ex_valid_i(ex_valid), .ex_is_load_i(ex_isLoad), .ex_dst_i(ex_dst),
        .ex_result_i(ex_result), .mem_valid_i(mem_valid), .mem_dst_i(mem_dst),
        .mem_result_i(mem_result), .op_o(op_t), .load_hit_o(hit_t)
    );

    operand_forward_mux u_mux_m (
        .src_i(idx_m), .rf_i(readResultM),
        .ex_valid_i(ex_valid), .ex_is_load_i(ex_isLoad), .ex_dst_i(ex_dst),
        .ex_result_i(ex_result), .mem_valid_i(mem_valid), .mem_dst_i(mem_dst),
        .mem_result_i(mem_result), .op_o(op_m), .load_hit_o(hit_m)
    );

    always_comb begin
        if (ex_valid && ex_writesT) begin
            t_fwd = ex_t;
        end else if (mem_valid && mem_writesT) begin
            t_fwd = mem_t;
        end else begin
            t_fwd = tResult;
        end
    end

    assign hazard           = dec_io.in_valid && (hit_s || hit_t || hit_m);
    assign dec_io.stall_out = stall_in || hazard;

    always_comb begin
        idex_d        = idex_q;
        stall_count_d = stall_count_q;
        if (flush) begin
            idex_d.valid = 1'b0;
            idex_d.dst   = REG_NONE;
        end else if (stall_in) begin
            idex_d = idex_q;
        end else if (hazard) begin
            idex_d.valid    = 1'b0;
            idex_d.dst      = REG_NONE;
            idex_d.writes_t = 1'b0;
            if (stall_count_q != '1) begin
                stall_count_d = stall_count_q + 1'b1;
            end
        end else begin
            idex_d.valid    = dec_io.in_valid;
            idex_d.dst      = dec_io.in_dst;
            idex_d.writes_t = dec_io.in_writesT;
            idex_d.is_load  = dec_io.in_isLoad;
            idex_d.t        = t_fwd;
            idex_d.op_s     = op_s;
            idex_d.op_t     = op_t;
            idex_d.op_m     = op_m;
            idex_d.ctrl     = dec_io.in_ctrl;
            idex_d.imm      = dec_io.in_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q        <= idex_reset();
            stall_count_q <= '0;
        end else begin
            idex_q        <= idex_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign out_valid   = idex_q.valid;
    assign out_dst     = idex_q.dst;
    assign out_writesT = idex_q.writes_t;
    assign out_isLoad  = idex_q.is_load;
    assign out_t       = idex_q.t;
    assign out_opS     = idex_q.op_s;
    assign out_opT     = idex_q.op_t;
    assign out_opM     = idex_q.op_m;
    assign out_ctrl    = idex_q.ctrl;
    assign out_imm     = idex_q.imm;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: directed plan cases then randomized cycles.
module tb_operand_fetch_stage;
    import cpu_defs::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    operand_fetch_stage_if dec_if ();

    idx_t        readIndexS, readIndexT, readIndexM;
    data_t       readResultS, readResultT, readResultM;
    logic        tResult;
    logic        ex_valid, ex_isLoad, ex_writesT, ex_t;
    idx_t        ex_dst;
    data_t       ex_result;
    logic        mem_valid, mem_writesT, mem_t;
    idx_t        mem_dst;
    data_t       mem_result;
    logic        stall_in, flush;
    logic        out_valid, out_t, out_writesT, out_isLoad;
    data_t       out_opS, out_opT, out_opM, out_imm;
    idx_t        out_dst;
    logic [15:0] out_ctrl;
    logic [15:0] stall_count;

    operand_fetch_stage dut (
        .clk(clk), .rst(rst), .dec_io(dec_if),
        .readIndexS(readIndexS), .readIndexT(readIndexT), .readIndexM(readIndexM),
        .readResultS(readResultS), .readResultT(readResultT), .readResultM(readResultM),
        .tResult(tResult),
        .ex_valid(ex_valid), .ex_isLoad(ex_isLoad), .ex_writesT(ex_writesT), .ex_t(ex_t),
        .ex_dst(ex_dst), .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_writesT(mem_writesT), .mem_t(mem_t),
        .mem_dst(mem_dst), .mem_result(mem_result),
        .stall_in(stall_in), .flush(flush),
        .out_valid(out_valid), .out_opS(out_opS), .out_opT(out_opT), .out_opM(out_opM),
        .out_t(out_t), .out_dst(out_dst), .out_writesT(out_writesT), .out_isLoad(out_isLoad),
        .out_ctrl(out_ctrl), .out_imm(out_imm), .stall_count(stall_count)
    );

    typedef struct {
        logic rst, in_valid, useT, wT, ld, tres;
        idx_t s, t, m, dst;
        logic [15:0] ctrl;
        data_t imm, rrS, rrT, rrM;
        logic exv, exld, exwt, ext;
        idx_t exdst;
        data_t exres;
        logic memv, memwt, memt;
        idx_t memdst;
        data_t memres;
        logic stall_in, flush;
    } stim_t;

    typedef struct {
        logic valid, wt, ld, t;
        idx_t dst;
        data_t opS, opT, opM, imm;
        logic [15:0] ctrl;
        int cnt;
        logic def, wt_def;
        logic stall_out;
        idx_t riS, riT, riM;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int total = 0;
    int bad = 0;

    function automatic logic legal(idx_t i);
        return (i != 4'hF) && !(i >= 4'd11 && i <= 4'd14);
    endfunction

    function automatic data_t ref_op(idx_t i, data_t rr, stim_t s);
        if (!legal(i)) return 16'h0;
        if (s.exv && !s.exld && s.exdst == i) return s.exres;
        if (s.memv && s.memdst == i) return s.memres;
        return rr;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.s = 4'hF; s.t = 4'hF; s.m = 4'hF; s.dst = 4'hF;
        s.exdst = 4'hF; s.memdst = 4'hF;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        logic haz;
        @(negedge clk);
        rst = s.rst;
        dec_if.in_valid = s.in_valid; dec_if.in_idxS = s.s; dec_if.in_idxT = s.t;
        dec_if.in_idxM = s.m; dec_if.in_dst = s.dst; dec_if.in_useT = s.useT;
        dec_if.in_writesT = s.wT; dec_if.in_isLoad = s.ld; dec_if.in_ctrl = s.ctrl;
        dec_if.in_imm = s.imm;
        readResultS = s.rrS; readResultT = s.rrT; readResultM = s.rrM; tResult = s.tres;
        ex_valid = s.exv; ex_isLoad = s.exld; ex_writesT = s.exwt; ex_t = s.ext;
        ex_dst = s.exdst; ex_result = s.exres;
        mem_valid = s.memv; mem_writesT = s.memwt; mem_t = s.memt;
        mem_dst = s.memdst; mem_result = s.memres;
        stall_in = s.stall_in; flush = s.flush;

        haz = s.in_valid && s.exv && s.exld &&
              ((legal(s.s) && s.s == s.exdst) || (legal(s.t) && s.t == s.exdst) ||
               (legal(s.m) && s.m == s.exdst));
        if (s.rst) begin
            m = '{default: '0};
            m.dst = 4'hF; m.def = 1'b1; m.wt_def = 1'b1;
        end else if (s.flush) begin
            m.valid = 1'b0; m.dst = 4'hF; m.def = 1'b0; m.wt_def = 1'b0;
        end else if (s.stall_in) begin
            m = m;
        end else if (haz) begin
            m.valid = 1'b0; m.dst = 4'hF; m.wt = 1'b0; m.wt_def = 1'b1; m.def = 1'b0;
            if (m.cnt < 65535) m.cnt = m.cnt + 1;
        end else begin
            m.valid = s.in_valid; m.dst = s.dst; m.wt = s.wT; m.ld = s.ld;
            m.t = (s.exv && s.exwt) ? s.ext : (s.memv && s.memwt) ? s.memt : s.tres;
            m.opS = ref_op(s.s, s.rrS, s); m.opT = ref_op(s.t, s.rrT, s);
            m.opM = ref_op(s.m, s.rrM, s);
            m.ctrl = s.ctrl; m.imm = s.imm; m.def = 1'b1; m.wt_def = 1'b1;
        end
        e = m;
        e.stall_out = s.stall_in | haz;
        e.riS = legal(s.s) ? s.s : 4'hF;
        e.riT = legal(s.t) ? s.t : 4'hF;
        e.riM = legal(s.m) ? s.m : 4'hF;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: the registered outputs and the still-held comb outputs settle by posedge+1.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall_out", 32'(dec_if.stall_out), 32'(e.stall_out));
                chk("readIndexS", 32'(readIndexS), 32'(e.riS));
                chk("readIndexT", 32'(readIndexT), 32'(e.riT));
                chk("readIndexM", 32'(readIndexM), 32'(e.riM));
                chk("out_valid", 32'(out_valid), 32'(e.valid));
                chk("out_dst", 32'(out_dst), 32'(e.dst));
                chk("stall_count", 32'(stall_count), 32'(e.cnt));
                if (e.wt_def) chk("out_writesT", 32'(out_writesT), 32'(e.wt));
                if (e.def) begin
                    chk("out_isLoad", 32'(out_isLoad), 32'(e.ld));
                    chk("out_t", 32'(out_t), 32'(e.t));
                    chk("out_opS", 32'(out_opS), 32'(e.opS));
                    chk("out_opT", 32'(out_opT), 32'(e.opT));
                    chk("out_opM", 32'(out_opM), 32'(e.opM));
                    chk("out_ctrl", 32'(out_ctrl), 32'(e.ctrl));
                    chk("out_imm", 32'(out_imm), 32'(e.imm));
                end
            end
        end
    end

    function automatic idx_t rand_idx();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return idx_t'($urandom_range(0, 4));
        if (r < 8) return 4'hF;
        return idx_t'($urandom_range(5, 14));
    endfunction

    initial begin
        stim_t s;
        int wait_cycles;
        rst = 1'b1;
        s = idle(); s.rst = 1'b1;
        step(s); step(s);

        s = idle(); s.in_valid = 1'b1; s.s = 4'd3; s.rrS = 16'h1234; s.dst = 4'd1;
        step(s);

        s = idle(); s.in_valid = 1'b1; s.t = 4'd2; s.rrT = 16'h5555;
        s.exv = 1'b1; s.exdst = 4'd2; s.exres = 16'hAAAA;
        s.memv = 1'b1; s.memdst = 4'd2; s.memres = 16'hBBBB;
        step(s);
        s.exv = 1'b0;
        step(s);

        s = idle(); s.in_valid = 1'b1; s.s = 4'd9; s.dst = 4'd3;
        s.exv = 1'b1; s.exld = 1'b1; s.exdst = 4'd9; s.exres = 16'hDEAD;
        step(s);
        s.exv = 1'b0; s.exld = 1'b0; s.exdst = 4'hF;
        s.memv = 1'b1; s.memdst = 4'd9; s.memres = 16'h00F0;
        step(s);

        s = idle(); s.in_valid = 1'b1; s.useT = 1'b1;
        s.exv = 1'b1; s.exwt = 1'b1; s.ext = 1'b1; s.tres = 1'b0;
        step(s);

        s = idle(); s.in_valid = 1'b1; s.s = 4'd1; s.flush = 1'b1; s.stall_in = 1'b1;
        step(s);

        s = idle(); s.in_valid = 1'b1; s.s = 4'hC; s.rrS = 16'h7777;
        s.exv = 1'b1; s.exld = 1'b1; s.exdst = 4'hC;
        step(s);

        for (int i = 0; i < 500; i++) begin
            s.rst      = ($urandom_range(0, 49) == 0);
            s.in_valid = ($urandom_range(0, 3) != 0);
            s.s = rand_idx(); s.t = rand_idx(); s.m = rand_idx(); s.dst = rand_idx();
            s.useT = 1'($urandom); s.wT = 1'($urandom); s.ld = 1'($urandom);
            s.ctrl = 16'($urandom); s.imm = 16'($urandom);
            s.rrS = 16'($urandom); s.rrT = 16'($urandom); s.rrM = 16'($urandom);
            s.tres = 1'($urandom);
            s.exv = 1'($urandom); s.exld = ($urandom_range(0, 2) == 0);
            s.exwt = 1'($urandom); s.ext = 1'($urandom);
            s.exdst = rand_idx(); s.exres = 16'($urandom);
            s.memv = 1'($urandom); s.memwt = 1'($urandom); s.memt = 1'($urandom);
            s.memdst = rand_idx(); s.memres = 16'($urandom);
            s.stall_in = ($urandom_range(0, 7) == 0);
            s.flush    = ($urandom_range(0, 9) == 0);
            step(s);
        end

        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
